// File: rtl/demodulation_acc_pkg.sv
// Shared definitions for the square-wave demodulation accumulator:
// FSM state encoding and the guard widths used by the saturating adders.
package demodulation_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACCUM = 2'd2
  } state_t;

  // One guard bit above the result width is enough to detect overflow of a
  // two-operand signed add/subtract; both saturating paths rely on exactly one.
  localparam int SAT_GUARD  = 1;
  localparam int DIFF_GUARD = 1;

  // Width of the settling-window counter and its reload input.
  localparam int WAIT_W = 32;

endpackage

// File: rtl/demodulation_acc_sat_accum.sv
// Signed saturating accumulator: clear has priority over add, and the sum
// clamps at the signed max/min of ACC_W instead of wrapping.
module sat_accum
  import demodulation_acc_pkg::*;
#(
  parameter int IN_W  = 14,
  parameter int ACC_W = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic signed [IN_W-1:0]  i_din,
  output logic signed [ACC_W-1:0] o_acc
);

  localparam int SUM_W = ACC_W + SAT_GUARD;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [SUM_W-1:0] sum_w;

  assign sum_w = {{SAT_GUARD{acc_q[ACC_W-1]}}, acc_q}
               + {{(SUM_W-IN_W){i_din[IN_W-1]}}, i_din};

  // Next accumulator value: clear, saturating add, or hold.
  always_comb begin
    acc_d = acc_q;
    if (i_clr) begin
      acc_d = '0;
    end else if (i_en) begin
      if (sum_w[SUM_W-1] != sum_w[ACC_W-1]) begin
        acc_d = sum_w[SUM_W-1] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_d = sum_w[ACC_W-1:0];
      end
    end
  end

  // Accumulator register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end

  assign o_acc = acc_q;

endmodule

// File: rtl/demodulation_acc.sv
// Square-wave demodulator: integrates the settled part of each modulation
// half, then reports sum_H - sum_L (optionally inverted, saturated) once per
// complete LOW-then-HIGH pair.
//
// Handshake: there is no backpressure. i_stepTrig is a single-cycle pulse
// with i_status already at the new level; o_valid is a single-cycle strobe
// and o_err is meaningful on that cycle and holds until the next strobe.
module demodulation_acc
  import demodulation_acc_pkg::*;
#(
  parameter int ADC_BIT = 14,
  parameter int ACC_BIT = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_status,
  input  logic                      i_stepTrig,
  input  logic signed [ADC_BIT-1:0] i_adc_data,
  input  logic [WAIT_W-1:0]         i_wait_cnt,
  input  logic                      i_polarity,
  output logic signed [ACC_BIT-1:0] o_err,
  output logic                      o_valid,
  output logic                      o_short,
  output logic [1:0]                o_dbg_state
);

  localparam int DIFF_W = ACC_BIT + DIFF_GUARD;
  localparam logic signed [ACC_BIT-1:0] ERR_MAX = {1'b0, {(ACC_BIT-1){1'b1}}};
  localparam logic signed [ACC_BIT-1:0] ERR_MIN = {1'b1, {(ACC_BIT-1){1'b0}}};

  state_t                    state_q, state_d;
  logic [WAIT_W-1:0]         wait_q, wait_d;
  logic signed [ADC_BIT-1:0] adc_d1_q;
  logic                      pol_q;
  logic signed [ACC_BIT-1:0] sum_h_q, sum_h_d;
  logic signed [ACC_BIT-1:0] sum_l_q, sum_l_d;
  logic                      good_l_q, good_l_d;
  logic signed [ACC_BIT-1:0] err_q, err_d;
  logic                      valid_q, valid_d;
  logic                      short_q, short_d;

  logic                      acc_clr, acc_en;
  logic signed [ACC_BIT-1:0] acc_val;
  logic signed [DIFF_W-1:0]  diff_w, adj_w;
  logic signed [ACC_BIT-1:0] err_sat_w;

  // Input pipeline: one register on the sample and on the polarity control.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      adc_d1_q <= '0;
      pol_q    <= 1'b0;
    end else begin
      adc_d1_q <= i_adc_data;
      pol_q    <= i_polarity;
    end
  end

  sat_accum #(
    .IN_W  (ADC_BIT),
    .ACC_W (ACC_BIT)
  ) u_acc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (acc_clr),
    .i_en    (acc_en),
    .i_din   (adc_d1_q),
    .o_acc   (acc_val)
  );

  // Differencer: the HIGH sum is taken straight from the accumulator on the
  // edge that ends the HIGH half, so the result registers on that same edge.
  always_comb begin
    diff_w = {{DIFF_GUARD{acc_val[ACC_BIT-1]}}, acc_val}
           - {{DIFF_GUARD{sum_l_q[ACC_BIT-1]}}, sum_l_q};
    adj_w  = pol_q ? -diff_w : diff_w;
    if (adj_w[DIFF_W-1] != adj_w[ACC_BIT-1]) begin
      err_sat_w = adj_w[DIFF_W-1] ? ERR_MIN : ERR_MAX;
    end else begin
      err_sat_w = adj_w[ACC_BIT-1:0];
    end
  end

  // FSM next state, half bookkeeping and pair evaluation.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    sum_h_d  = sum_h_q;
    sum_l_d  = sum_l_q;
    good_l_d = good_l_q;
    err_d    = err_q;
    valid_d  = 1'b0;
    short_d  = short_q;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_stepTrig) begin
          good_l_d = 1'b0;
        end
      end
      ST_WAIT, ST_ACCUM: begin
        if (i_stepTrig) begin
          if (state_q == ST_ACCUM) begin
            if (!i_status) begin
              // A HIGH half just finished cleanly.
              sum_h_d  = acc_val;
              if (good_l_q) begin
                err_d   = err_sat_w;
                valid_d = 1'b1;
              end
              good_l_d = 1'b0;
            end else begin
              // A LOW half just finished cleanly.
              sum_l_d  = acc_val;
              good_l_d = 1'b1;
            end
          end else begin
            // Half ended while still settling: unusable, and any open pair dies.
            short_d  = 1'b1;
            good_l_d = 1'b0;
          end
        end else if (state_q == ST_WAIT) begin
          if (wait_q <= 1) state_d = ST_ACCUM;
          wait_d = (wait_q == '0) ? '0 : wait_q - 1'b1;
        end else begin
          acc_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Every edge starts a new half: clear, reload the settling window, and
    // skip straight to accumulation when no settling is requested.
    if (i_stepTrig && (state_q inside {ST_IDLE, ST_WAIT, ST_ACCUM})) begin
      acc_clr = 1'b1;
      wait_d  = i_wait_cnt;
      state_d = (i_wait_cnt == '0) ? ST_ACCUM : ST_WAIT;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      wait_q   <= '0;
      sum_h_q  <= '0;
      sum_l_q  <= '0;
      good_l_q <= 1'b0;
      err_q    <= '0;
      valid_q  <= 1'b0;
      short_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      sum_h_q  <= sum_h_d;
      sum_l_q  <= sum_l_d;
      good_l_q <= good_l_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      short_q  <= short_d;
    end
  end

  assign o_err       = err_q;
  assign o_valid     = valid_q;
  assign o_short     = short_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_demodulation_acc.sv
// Directed bench for demodulation_acc. Two instances share the stimulus:
// dut_a with the default 32-bit accumulator and dut_b with a 24-bit one to
// exercise clamping. Inputs change on the falling edge, outputs are sampled
// on the falling edge.
module tb_demodulation_acc;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               status;
  logic               trig;
  logic signed [13:0] adc;
  logic [31:0]        wait_cnt;
  logic               pol;

  logic signed [31:0] err_a;
  logic               valid_a, short_a;
  logic [1:0]         dbg_a;
  logic signed [23:0] err_b;
  logic               valid_b, short_b;
  logic [1:0]         dbg_b;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     vcnt_a, voff_a, vcnt_b, voff_b;
  longint verr_a, verr_b;

  // Clock and DUTs
  always #5 clk = ~clk;

  demodulation_acc #(.ADC_BIT(14), .ACC_BIT(32)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_status(status), .i_stepTrig(trig),
    .i_adc_data(adc), .i_wait_cnt(wait_cnt), .i_polarity(pol),
    .o_err(err_a), .o_valid(valid_a), .o_short(short_a), .o_dbg_state(dbg_a)
  );

  demodulation_acc #(.ADC_BIT(14), .ACC_BIT(24)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_status(status), .i_stepTrig(trig),
    .i_adc_data(adc), .i_wait_cnt(wait_cnt), .i_polarity(pol),
    .o_err(err_b), .o_valid(valid_b), .o_short(short_b), .o_dbg_state(dbg_b)
  );

  // Single comparison point
  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver: one modulation half of len cycles, edge pulse on the first cycle,
  // constant sample value. Records o_valid pulses seen during the half
  // (offset 1 = the cycle right after this half's starting edge).
  task automatic run_half(input logic lvl, input int len, input logic signed [13:0] val);
    vcnt_a = 0; voff_a = -1; vcnt_b = 0; voff_b = -1;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (valid_a) begin
        vcnt_a++;
        if (voff_a < 0) voff_a = i;
        verr_a = err_a;
      end
      if (valid_b) begin
        vcnt_b++;
        if (voff_b < 0) voff_b = i;
        verr_b = err_b;
      end
      trig   = (i == 0);
      status = lvl;
      adc    = val;
    end
  endtask

  initial begin
    rst_n = 1'b0; status = 1'b0; trig = 1'b0; adc = '0; wait_cnt = 32'd10; pol = 1'b0;
    verr_a = 0; verr_b = 0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_err_a",   err_a,   0);
    chk("rst_valid_a", valid_a, 0);
    chk("rst_short_a", short_a, 0);
    chk("rst_state_a", dbg_a,   0);
    chk("rst_err_b",   err_b,   0);
    rst_n = 1'b1;

    // Nominal pair, polarity 0: 89 accumulated samples per 100-cycle half
    run_half(1'b0, 100, 14'sd20);
    chk("nom_lowfirst_vcnt", vcnt_a, 0);
    run_half(1'b1, 100, 14'sd50);
    chk("nom_high_vcnt", vcnt_a, 0);
    run_half(1'b0, 100, 14'sd20);
    chk("nom_vcnt_a",  vcnt_a, 1);
    chk("nom_voff_a",  voff_a, 1);
    chk("nom_err_a",   verr_a, 2670);
    chk("nom_err_b",   verr_b, 2670);
    chk("nom_sum_h",   dut_a.sum_h_q, 4450);
    chk("nom_sum_l",   dut_a.sum_l_q, 1780);
    chk("nom_hold_err",   err_a, 2670);
    chk("nom_hold_valid", valid_a, 0);
    chk("nom_short",      short_a, 0);

    // Same stimulus, inverted polarity
    pol = 1'b1;
    run_half(1'b1, 100, 14'sd50);
    chk("inv_high_vcnt", vcnt_a, 0);
    run_half(1'b0, 100, 14'sd20);
    chk("inv_vcnt_a", vcnt_a, 1);
    chk("inv_voff_a", voff_a, 1);
    chk("inv_err_a",  verr_a, -2670);
    chk("inv_err_b",  verr_b, -2670);

    // Settling window longer than the half: short flag, never a strobe
    pol = 1'b0;
    wait_cnt = 32'd150;
    run_half(1'b1, 100, 14'sd50);
    chk("short_pre_vcnt",  vcnt_a, 0);
    chk("short_pre_flag",  short_a, 0);
    run_half(1'b0, 100, 14'sd20);
    chk("short_vcnt1", vcnt_a, 0);
    chk("short_flag",  short_a, 1);
    run_half(1'b1, 100, 14'sd50);
    chk("short_vcnt2", vcnt_a, 0);
    run_half(1'b0, 100, 14'sd20);
    chk("short_vcnt3", vcnt_a + vcnt_b, 0);
    chk("short_sticky", short_a, 1);

    // Reset mid-HIGH with a good LOW pending
    wait_cnt = 32'd10;
    run_half(1'b1, 100, 14'sd50);
    run_half(1'b0, 100, 14'sd20);
    chk("rec_vcnt", vcnt_a, 0);
    run_half(1'b1, 50, 14'sd50);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_err",   err_a,   0);
    chk("mid_rst_valid", valid_a, 0);
    chk("mid_rst_short", short_a, 0);
    chk("mid_rst_state", dbg_a,   0);
    chk("mid_rst_suml",  dut_a.sum_l_q, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset opens a HIGH half: strobe only after L then H
    run_half(1'b1, 100, 14'sd50);
    chk("post_h0_vcnt", vcnt_a, 0);
    run_half(1'b0, 100, 14'sd20);
    chk("post_l1_vcnt", vcnt_a, 0);
    run_half(1'b1, 100, 14'sd50);
    chk("post_h1_vcnt", vcnt_a, 0);
    run_half(1'b0, 100, 14'sd20);
    chk("post_vcnt", vcnt_a, 1);
    chk("post_voff", voff_a, 1);
    chk("post_err",  verr_a, 2670);

    // Saturation: 1189 samples of +8191 overflow 24 bits but not 32 bits
    run_half(1'b1, 100, 14'sd50);
    run_half(1'b0, 1200, 14'sd0);
    chk("sat_prev_err", verr_a, 2670);
    run_half(1'b1, 1200, 14'sd8191);
    chk("sat_high_vcnt", vcnt_b, 0);
    chk("sat_acc_b", dut_b.u_acc.o_acc, 8388607);
    run_half(1'b0, 100, 14'sd0);
    chk("sat_vcnt_b", vcnt_b, 1);
    chk("sat_voff_b", voff_b, 1);
    chk("sat_err_b",  verr_b, 8388607);
    chk("sat_err_a",  verr_a, 9739099);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
